// File: rtl/rgb_led_arbiter.sv
// ============================================================================
// rgb_led_arbiter
//
// Round-robin arbiter that lends a single active-low RGB LED to one of
// NUM_REQ requesters at a time. The winner's 3-bit colour is latched when it
// is granted. That colour is then shown for exactly HOLD_CYCLES clocks. At
// least one LED-off cycle follows before the next grant.
//
// Parameters
//   NUM_REQ      number of requesters (2..8)
//   HOLD_CYCLES  clocks each granted colour stays lit (>= 2)
//
// Ports
//   clk            single clock, all logic on its rising edge
//   rst            asynchronous active-high reset
//   req   [N]      level request per slot
//   color [3N]     slot i colour at [3i+2:3i] = {R,G,B}, 1 = on
//   grant [N]      one-cycle pulse in the first cycle a slot is shown
//   done  [N]      one-cycle pulse in the cycle after a slot's hold ends
//   busy           high while a colour is being shown
//   RGB_R/G/B      LED drives, active-low
//
// Build option
//   RGB_ARB_PREEMPT_EN  when defined, a request on slot 0 preempts any other
//                       owner mid-hold. done[owner] and grant[0] pulse in the
//                       same cycle. The default build has no preemption.
// ============================================================================
module rgb_led_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int HOLD_CYCLES = 2000000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [3*NUM_REQ-1:0]   color,
    output logic [NUM_REQ-1:0]     grant,
    output logic [NUM_REQ-1:0]     done,
    output logic                   busy,
    output logic                   RGB_R,
    output logic                   RGB_G,
    output logic                   RGB_B
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(HOLD_CYCLES);

    typedef enum logic {
        IDLE = 1'b0,
        SHOW = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [IW-1:0]        ptr_q, ptr_d;
    logic [IW-1:0]        owner_q, owner_d;
    logic [CW-1:0]        count_q, count_d;
    logic [2:0]           color_q, color_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [NUM_REQ-1:0]   done_q, done_d;

    // Per-slot view of the packed colour bus
    logic [2:0]           color_slot [NUM_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_slot
            assign color_slot[gi] = color[3*gi +: 3];
        end
    endgenerate

    // Round-robin scan. Start at ptr and wrap modulo NUM_REQ. The first
    // requester found wins. The extra sum bit covers the wrap for NUM_REQ
    // values that are not a power of two.
    logic [IW:0]          scan_sum;
    logic                 win_found;
    logic [IW-1:0]        win_idx;

    always_comb begin
        scan_sum  = '0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_sum = {1'b0, ptr_q} + (IW+1)'(k);
            if (scan_sum >= (IW+1)'(NUM_REQ)) begin
                scan_sum = scan_sum - (IW+1)'(NUM_REQ);
            end
            if (!win_found && req[scan_sum[IW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = scan_sum[IW-1:0];
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        count_d = count_q;
        color_d = color_q;
        grant_d = '0;
        done_d  = '0;

        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d = SHOW;
                    owner_d = win_idx;
                    count_d = '0;
                    color_d = color_slot[win_idx];
                    grant_d = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx;
                    ptr_d   = (win_idx == IW'(NUM_REQ-1)) ? '0 : win_idx + IW'(1);
                end
            end

            SHOW: begin
`ifdef RGB_ARB_PREEMPT_EN
                // Slot 0 takes over mid-hold. Preemption outranks a hold
                // that ends at the same edge, and done fires either way.
                if (req[0] && (owner_q != '0)) begin
                    done_d  = {{(NUM_REQ-1){1'b0}}, 1'b1} << owner_q;
                    grant_d = {{(NUM_REQ-1){1'b0}}, 1'b1};
                    color_d = color_slot[0];
                    owner_d = '0;
                    count_d = '0;
                    ptr_d   = IW'(1);
                end else
`endif
                if (count_q == CW'(HOLD_CYCLES-1)) begin
                    state_d = IDLE;
                    count_d = '0;
                    done_d  = {{(NUM_REQ-1){1'b0}}, 1'b1} << owner_q;
                end else begin
                    count_d = count_q + CW'(1);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            count_q <= '0;
            color_q <= '0;
            grant_q <= '0;
            done_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            count_q <= count_d;
            color_q <= color_d;
            grant_q <= grant_d;
            done_q  <= done_d;
        end
    end

    assign grant = grant_q;
    assign done  = done_q;
    assign busy  = (state_q == SHOW);

    // The LED is active-low. It shows the inverted latched colour only while
    // busy and is otherwise off.
    always_comb begin
        if (state_q == SHOW) begin
            {RGB_R, RGB_G, RGB_B} = ~color_q;
        end else begin
            {RGB_R, RGB_G, RGB_B} = 3'b111;
        end
    end

endmodule

// File: tb/tb_rgb_led_arbiter.sv
// ============================================================================
// tb_rgb_led_arbiter
//
// Self-checking bench for rgb_led_arbiter with NUM_REQ = 4 and
// HOLD_CYCLES = 4. The stimulus process queues the observations it expects
// with absolute cycle numbers. Each observation holds the grant, done, RGB
// and busy values. The monitor samples on the falling edge. It pops a record
// whenever a grant/done pulse appears or a queued probe cycle is reached.
// Expectations for the preemption case follow RGB_ARB_PREEMPT_EN.
// ============================================================================
module tb_rgb_led_arbiter;

    localparam int NUM_REQ     = 4;
    localparam int HOLD_CYCLES = 4;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [NUM_REQ-1:0]   req = '0;
    logic [3*NUM_REQ-1:0] color = '0;
    logic [NUM_REQ-1:0]   grant;
    logic [NUM_REQ-1:0]   done;
    logic                 busy;
    logic                 RGB_R, RGB_G, RGB_B;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int         cyc;
        logic [3:0] grant;
        logic [3:0] done;
        logic [2:0] rgb;
        logic       busy;
    } exp_t;

    exp_t exp_q[$];

    rgb_led_arbiter #(
        .NUM_REQ     (NUM_REQ),
        .HOLD_CYCLES (HOLD_CYCLES)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .color (color),
        .grant (grant),
        .done  (done),
        .busy  (busy),
        .RGB_R (RGB_R),
        .RGB_G (RGB_G),
        .RGB_B (RGB_B)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void expect_at(int c, logic [3:0] g, logic [3:0] d,
                                      logic [2:0] rgb, logic b);
        exp_t e;
        e.cyc   = c;
        e.grant = g;
        e.done  = d;
        e.rgb   = rgb;
        e.busy  = b;
        exp_q.push_back(e);
    endfunction

    // Advance n clock edges, then settle 1 time unit past the edge
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string name);
        checks++;
        if (grant !== 4'b0 || done !== 4'b0 || busy !== 1'b0 ||
            {RGB_R, RGB_G, RGB_B} !== 3'b111) begin
            errors++;
            $display("FAIL %s: grant=%b done=%b busy=%b rgb=%b, want 0000 0000 0 111",
                     name, grant, done, busy, {RGB_R, RGB_G, RGB_B});
        end else begin
            $display("ok   %s: idle outputs at cycle %0d", name, cyc);
        end
    endtask

    // Monitor: sample on the falling edge
    always @(negedge clk) begin
        exp_t e;
        logic ev;
        ev = (grant !== 4'b0) || (done !== 4'b0);
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            e = exp_q.pop_front();
            checks++;
            errors++;
            $display("FAIL missed: cycle %0d passed without grant=%b done=%b rgb=%b (now cycle %0d)",
                     e.cyc, e.grant, e.done, e.rgb, cyc);
        end
        if (ev || (exp_q.size() > 0 && exp_q[0].cyc == cyc)) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected: cycle %0d grant=%b done=%b with nothing expected",
                         cyc, grant, done);
            end else begin
                e = exp_q.pop_front();
                if (e.cyc != cyc || e.grant !== grant || e.done !== done ||
                    e.rgb !== {RGB_R, RGB_G, RGB_B} || e.busy !== busy) begin
                    errors++;
                    $display("FAIL event: got cyc=%0d grant=%b done=%b rgb=%b busy=%b, want cyc=%0d grant=%b done=%b rgb=%b busy=%b",
                             cyc, grant, done, {RGB_R, RGB_G, RGB_B}, busy,
                             e.cyc, e.grant, e.done, e.rgb, e.busy);
                end else begin
                    $display("ok   event: cyc=%0d grant=%b done=%b rgb=%b busy=%b",
                             cyc, grant, done, {RGB_R, RGB_G, RGB_B}, busy);
                end
            end
        end
    end

    initial begin
        int c0;

        // Reset is held with every slot requesting, so the LED must stay off
        req   = 4'b1111;
        color = 12'b111_001_010_100;
        for (int i = 0; i < 3; i++) begin
            step(1);
            check_idle("reset_hold");
        end
        rst = 1'b0;
        req = 4'b0000;
        step(1);

        // A single request on slot 2 with colour R+G, shown as RGB_B only
        c0 = cyc;
        req   = 4'b0100;
        color = {3'b000, 3'b110, 3'b000, 3'b000};
        expect_at(c0 + 1, 4'b0100, 4'b0000, 3'b001, 1'b1);
        expect_at(c0 + 4, 4'b0000, 4'b0000, 3'b001, 1'b1);
        expect_at(c0 + 5, 4'b0000, 4'b0100, 3'b111, 1'b0);
        step(1);
        req = 4'b0000;              // ignored during SHOW
        step(6);

        // Re-reset, then all slots request: the grant order is 0,1,2,3,0
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        c0 = cyc;
        req   = 4'b1111;
        color = {3'b111, 3'b001, 3'b010, 3'b100};
        for (int k = 0; k < 5; k++) begin
            logic [2:0] rgb_k;
            case (k % 4)
                0: rgb_k = 3'b011;
                1: rgb_k = 3'b101;
                2: rgb_k = 3'b110;
                default: rgb_k = 3'b000;
            endcase
            expect_at(c0 + 1 + 5*k, 4'b0001 << (k % 4), 4'b0000, rgb_k, 1'b1);
            expect_at(c0 + 5 + 5*k, 4'b0000, 4'b0001 << (k % 4), 3'b111, 1'b0);
        end
        step(21);
        req = 4'b0000;              // inside the final slot 0 hold
        step(6);

        // Reset mid-hold of slot 1: no done, and the scan restarts at ptr 0
        c0 = cyc;
        req   = 4'b0010;
        color = {3'b000, 3'b000, 3'b010, 3'b000};
        expect_at(c0 + 1, 4'b0010, 4'b0000, 3'b101, 1'b1);
        step(2);                    // cycle 2 of the hold
        rst = 1'b1;
        req = 4'b1010;
        #1;
        check_idle("reset_mid_hold");
        step(1);
        rst = 1'b0;
        expect_at(c0 + 4, 4'b0010, 4'b0000, 3'b101, 1'b1);
        expect_at(c0 + 8, 4'b0000, 4'b0010, 3'b111, 1'b0);
        step(1);
        req = 4'b0000;
        step(6);

        // A colour change during the slot 3 hold is ignored
        c0 = cyc;
        req   = 4'b1000;
        color = {3'b001, 3'b000, 3'b000, 3'b000};
        expect_at(c0 + 1, 4'b1000, 4'b0000, 3'b110, 1'b1);
        expect_at(c0 + 3, 4'b0000, 4'b0000, 3'b110, 1'b1);
        expect_at(c0 + 4, 4'b0000, 4'b0000, 3'b110, 1'b1);
        expect_at(c0 + 5, 4'b0000, 4'b1000, 3'b111, 1'b0);
        step(1);
        req = 4'b0000;
        step(1);
        color = {3'b100, 3'b000, 3'b000, 3'b000};
        step(5);

        // Slot 0 requests while slot 2 is at count 1
        c0 = cyc;
        req   = 4'b0100;
        color = {3'b000, 3'b001, 3'b000, 3'b010};
        expect_at(c0 + 1, 4'b0100, 4'b0000, 3'b110, 1'b1);
        step(2);
        req = 4'b0001;
`ifdef RGB_ARB_PREEMPT_EN
        expect_at(c0 + 3, 4'b0001, 4'b0100, 3'b101, 1'b1);
        expect_at(c0 + 6, 4'b0000, 4'b0000, 3'b101, 1'b1);
        expect_at(c0 + 7, 4'b0000, 4'b0001, 3'b111, 1'b0);
        step(1);
        req = 4'b0000;
        step(6);
`else
        expect_at(c0 + 4, 4'b0000, 4'b0000, 3'b110, 1'b1);
        expect_at(c0 + 5, 4'b0000, 4'b0100, 3'b111, 1'b0);
        expect_at(c0 + 6, 4'b0001, 4'b0000, 3'b101, 1'b1);
        expect_at(c0 + 10, 4'b0000, 4'b0001, 3'b111, 1'b0);
        step(4);
        req = 4'b0000;
        step(6);
`endif

        // Every queued observation must have been consumed
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected observations left, want 0", exp_q.size());
        end else begin
            $display("ok   drain: scoreboard empty");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rgb_led_arbiter.md
RGB_LED_ARBITER -- requirements
Module: rgb_led_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, number of requesters (legal range 2..8).
REQ-002 The block SHALL have parameter HOLD_CYCLES, default 2000000, clk cycles each granted colour is shown (1/6 s at 12 MHz; legal minimum 2).
REQ-003 Port clk, input, 1, single clock; all logic on posedge.
REQ-004 Port rst, input, 1, asynchronous active-high reset.
REQ-005 Port req, input, NUM_REQ, level request per requester.
REQ-006 Port color, input, 3*NUM_REQ, requested colour for slot i at bits [3i+2:3i] = {R,G,B}; 1 = on.
REQ-007 Port grant, output, NUM_REQ, one-cycle pulse: slot's colour latched, hold started.
REQ-008 Port done, output, NUM_REQ, one-cycle pulse: slot's hold ended.
REQ-009 Port busy, output, 1, high while a colour is being shown.
REQ-010 Ports RGB_R, RGB_G, RGB_B, output, 1 each, LED drives, active-low.

Function
REQ-011 States SHALL be IDLE and SHOW only.
REQ-012 IDLE: RGB_R/G/B = 1 (off), busy = 0.
REQ-013 IDLE with req != 0 at a clk edge: SHALL select winner by round-robin scan from pointer ptr upward, modulo NUM_REQ; latch color of winner; set owner = winner, count = 0, ptr = (winner+1) mod NUM_REQ; enter SHOW.
REQ-014 grant[owner] SHALL be high in exactly the first SHOW cycle, all other grant bits 0.
REQ-015 SHOW: RGB_R/G/B SHALL equal bitwise inverse of latched colour; busy = 1; count increments each cycle.
REQ-016 SHOW with count == HOLD_CYCLES-1 at an edge: SHALL return to IDLE; done[owner] high in exactly that next (IDLE) cycle.
REQ-017 Colour SHALL be shown for exactly HOLD_CYCLES cycles; minimum one IDLE (LED off) cycle between consecutive holds.
REQ-018 req deassertion or color change during SHOW SHALL be ignored; no cancellation.
REQ-019 A requester still requesting on return to IDLE is eligible again; round-robin ordering SHALL prevent it from winning ahead of other pending requesters.
REQ-020 count width SHALL be $clog2(HOLD_CYCLES); ptr/owner width $clog2(NUM_REQ); no wrap-around of count beyond HOLD_CYCLES-1.
REQ-021 grant and done SHALL never be high for the same slot in the same cycle, and at most one bit of each is high at a time.

Reset
REQ-022 While rst = 1 (asynchronously, including mid-hold): state = IDLE, ptr = 0, owner = 0, count = 0, latched colour = 0, grant = 0, done = 0, busy = 0, RGB_R/G/B = 1.
REQ-023 Reset mid-hold SHALL NOT emit done for the aborted owner.
REQ-024 First edge after rst falls SHALL be evaluated as a normal IDLE cycle.

Configuration
REQ-025 Macro RGB_ARB_PREEMPT_EN SHALL, when defined, enable preemption by slot 0: in SHOW with owner != 0 and req[0] = 1 at an edge, the block SHALL pulse done[owner] and grant[0] in the next cycle, latch color slot 0, set owner = 0, count = 0, ptr = 1, remain in SHOW.
REQ-026 With preemption, done and grant SHALL fire for different slots in the same cycle; owner 0 SHALL never preempt itself.
REQ-027 Without RGB_ARB_PREEMPT_EN, req[0] SHALL receive no priority and wait as in REQ-013.

Verification (NUM_REQ = 4, HOLD_CYCLES = 4)
REQ-028 rst = 1 with req = 4'b1111 -> RGB = 3'b111, grant = 0, done = 0, busy = 0 throughout.
REQ-029 req[2] = 1, color slot 2 = 3'b110 sampled at edge E0 -> grant = 4'b0100 in cycle 1; RGB_R=0, RGB_G=0, RGB_B=1 in cycles 1..4; done = 4'b0100 and RGB = 3'b111 in cycle 5.
REQ-030 req = 4'b1111 held after reset -> grant order 0,1,2,3,0, each hold 4 cycles separated by one off cycle.
REQ-031 rst pulsed in cycle 2 of a slot 1 hold -> RGB = 3'b111 immediately, no done[1], next grant goes to lowest pending slot from ptr = 0.
REQ-032 color slot 3 changed from 3'b001 to 3'b100 in cycle 2 of slot 3 hold -> RGB stays 3'b110 (blue) until hold ends.
REQ-033 Slot 2 holding at count 1, req[0] = 1 with color slot 0 = 3'b010 -> with RGB_ARB_PREEMPT_EN: done = 4'b0100 and grant = 4'b0001 next cycle, RGB = 3'b101 for 4 cycles; without macro: slot 2 completes all 4 cycles, then slot 0 is granted.
